// File: rtl/apb_regfile_responder_if.sv
// APB bus bundle between the student-record master and the register-file responder.
// Clock and reset stay outside the bundle as plain ports of the modules.
interface apb_regfile_responder_if #(
  parameter int ADDR_W = 32
);
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [31:0]       PWDATA;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_regfile_responder.sv
// APB responder for the student-record register file: four RW words, a read-only ID,
// a completed-write counter, programmable wait states and PSLVERR on bad accesses.
module apb_regfile_responder #(
  parameter int          ADDR_W      = 32,
  parameter int          WAIT_STATES = 1,
  parameter int          CNT_W       = 8,
  parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
  input logic                    PCLK,
  input logic                    PRESET,
  apb_regfile_responder_if.slave apb
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  logic [0:0]       state_r;
  logic             wr_r;
  logic             err_r;
  logic [2:0]       idx_r;
  logic [3:0]       wait_r;
  logic             pready_r;
  logic             pslverr_r;
  logic [31:0]      prdata_r;
  logic [31:0]      regs_r [4];
  logic [CNT_W-1:0] cnt_r;

  logic             setup_s;
  logic             setup_err_s;
  logic [31:0]      setup_data_s;
  logic [31:0]      lat_data_s;

  // Misaligned, beyond WCNT, or a write to one of the two read-only words.
  function automatic logic decode_err(input logic [ADDR_W-1:0] addr, input logic wr);
    logic misaligned;
    logic out_of_range;
    logic ro_write;
    misaligned   = (addr[1:0] != 2'b00);
    out_of_range = (addr > ADDR_W'(32'h14));
    ro_write     = wr && ((addr == ADDR_W'(32'h10)) || (addr == ADDR_W'(32'h14)));
    return misaligned | out_of_range | ro_write;
  endfunction

  function automatic logic [31:0] read_value(input logic [2:0] idx);
    logic [31:0] val;
    case (idx)
      3'd0:    val = regs_r[0];
      3'd1:    val = regs_r[1];
      3'd2:    val = regs_r[2];
      3'd3:    val = regs_r[3];
      3'd4:    val = ID_VALUE;
      3'd5:    val = 32'(cnt_r);
      default: val = 32'd0;
    endcase
    return val;
  endfunction

  // Setup decode from the live bus and read data from the latched access.
  always_comb begin
    setup_s     = apb.PSEL && !apb.PENABLE;
    setup_err_s = decode_err(apb.PADDR, apb.PWRITE);
    if (setup_err_s || apb.PWRITE) begin
      setup_data_s = 32'd0;
    end else begin
      setup_data_s = read_value(apb.PADDR[4:2]);
    end
    if (err_r || wr_r) begin
      lat_data_s = 32'd0;
    end else begin
      lat_data_s = read_value(idx_r);
    end
  end

  // Transfer FSM, register file and write counter; a setup phase always restarts the access.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_r   <= ST_IDLE;
      wr_r      <= 1'b0;
      err_r     <= 1'b0;
      idx_r     <= 3'd0;
      wait_r    <= 4'd0;
      pready_r  <= 1'b0;
      pslverr_r <= 1'b0;
      prdata_r  <= 32'd0;
      cnt_r     <= {CNT_W{1'b0}};
      for (int i = 0; i < 4; i++) begin
        regs_r[i] <= 32'd0;
      end
    end else if (setup_s) begin
      state_r  <= ST_ACCESS;
      wr_r     <= apb.PWRITE;
      err_r    <= setup_err_s;
      idx_r    <= apb.PADDR[4:2];
      wait_r   <= WAIT_INIT;
      pready_r <= (WAIT_STATES == 0);
      if (WAIT_STATES == 0) begin
        prdata_r  <= setup_data_s;
        pslverr_r <= setup_err_s;
      end else begin
        prdata_r  <= 32'd0;
        pslverr_r <= 1'b0;
      end
    end else begin
      case (state_r)
        ST_ACCESS: begin
          if (!apb.PSEL) begin
            state_r   <= ST_IDLE;
            pready_r  <= 1'b0;
            pslverr_r <= 1'b0;
            prdata_r  <= 32'd0;
          end else if (!pready_r) begin
            wait_r <= wait_r - 4'd1;
            if (wait_r == 4'd1) begin
              pready_r  <= 1'b1;
              prdata_r  <= lat_data_s;
              pslverr_r <= err_r;
            end
          end else begin
            // Completion edge: PWDATA is taken now, not at setup.
            if (wr_r && !err_r) begin
              regs_r[idx_r[1:0]] <= apb.PWDATA;
              cnt_r              <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            state_r   <= ST_IDLE;
            pready_r  <= 1'b0;
            pslverr_r <= 1'b0;
            prdata_r  <= 32'd0;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          pready_r  <= 1'b0;
          pslverr_r <= 1'b0;
          prdata_r  <= 32'd0;
        end
      endcase
    end
  end

  assign apb.PRDATA  = prdata_r;
  assign apb.PREADY  = pready_r;
  assign apb.PSLVERR = pslverr_r;

endmodule

// File: tb/tb_apb_regfile_responder.sv
// Bench for apb_regfile_responder: three instances (0, 1 and 3 wait states) driven
// by a simple APB master task and checked against tables and a behavioural model.
module tb_apb_regfile_responder;

  localparam logic [31:0] ID = 32'hA9B0_0001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        psel_a    [3];
  logic        penable_a [3];
  logic        pwrite_a  [3];
  logic [31:0] paddr_a   [3];
  logic [31:0] pwdata_a  [3];
  logic [31:0] prdata_a  [3];
  logic        pready_a  [3];
  logic        pslverr_a [3];

  int checks = 0;
  int errors = 0;

  logic [31:0] m_regs [3][4];
  int          m_wcnt [3];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vecs [21];

  genvar g;
  for (g = 0; g < 3; g++) begin : gen_dut
    localparam int WS = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    apb_regfile_responder_if #(.ADDR_W(32)) bus ();
    assign bus.PSEL      = psel_a[g];
    assign bus.PENABLE   = penable_a[g];
    assign bus.PWRITE    = pwrite_a[g];
    assign bus.PADDR     = paddr_a[g];
    assign bus.PWDATA    = pwdata_a[g];
    assign prdata_a[g]   = bus.PRDATA;
    assign pready_a[g]   = bus.PREADY;
    assign pslverr_a[g]  = bus.PSLVERR;
    apb_regfile_responder #(
      .ADDR_W(32), .WAIT_STATES(WS), .CNT_W(8), .ID_VALUE(ID)
    ) dut (
      .PCLK(clk), .PRESET(rst), .apb(bus.slave)
    );
  end

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
  endfunction

  function automatic vec_t mk(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input bit exp_err);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_wcnt[d] = 0;
      for (int r = 0; r < 4; r++) m_regs[d][r] = 32'd0;
    end
  endtask

  // Address-map rules: what a transfer should report, from current model contents.
  task automatic model_expect(input int d, input bit wr, input logic [31:0] addr,
                              output logic [31:0] rd, output bit er);
    er = 1'b0;
    rd = 32'd0;
    if ((addr % 4) != 0 || addr > 32'h14) begin
      er = 1'b1;
    end else if (addr >= 32'h10) begin
      er = wr;
      if (!wr) rd = (addr == 32'h10) ? ID : 32'(m_wcnt[d]);
    end else if (!wr) begin
      rd = m_regs[d][addr / 4];
    end
  endtask

  task automatic idle(input int d);
    @(negedge clk);
    psel_a[d]    = 1'b0;
    penable_a[d] = 1'b0;
  endtask

  task automatic do_xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err,
                         output logic [31:0] exp_rd, output bit exp_err);
    int waits;
    model_expect(d, wr, addr, exp_rd, exp_err);
    @(negedge clk);
    check("ready_low_before_setup", {31'd0, pready_a[d]}, 32'd0);
    psel_a[d] = 1'b1; penable_a[d] = 1'b0; pwrite_a[d] = wr;
    paddr_a[d] = addr; pwdata_a[d] = wdata;
    @(negedge clk);
    penable_a[d] = 1'b1;
    waits = 0;
    while (pready_a[d] !== 1'b1 && waits < 40) begin
      @(negedge clk);
      waits++;
    end
    check($sformatf("wait_states_dut%0d", d), 32'(waits), 32'(ws_of(d)));
    rdata = prdata_a[d];
    err   = pslverr_a[d];
    if (wr && !exp_err) begin
      m_regs[d][addr[3:2]] = wdata;
      m_wcnt[d] = (m_wcnt[d] + 1) % 256;
    end
  endtask

  task automatic check_xfer(input int d, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input string name);
    logic [31:0] rd, erd;
    logic        e;
    bit          ee;
    do_xfer(d, wr, addr, wdata, rd, e, erd, ee);
    check({name, "_err"}, {31'd0, e}, {31'd0, ee});
    if (!wr || ee) check({name, "_rdata"}, rd, erd);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, erd;
    logic        e;
    bit          ee;
    logic [31:0] pool [9];

    for (int d = 0; d < 3; d++) begin
      psel_a[d] = 1'b0; penable_a[d] = 1'b0; pwrite_a[d] = 1'b0;
      paddr_a[d] = 32'd0; pwdata_a[d] = 32'd0;
    end
    model_reset();

    vecs[0]  = mk(1'b0, 32'h00, 32'h0, 32'h0, 1'b0);
    vecs[1]  = mk(1'b0, 32'h04, 32'h0, 32'h0, 1'b0);
    vecs[2]  = mk(1'b0, 32'h08, 32'h0, 32'h0, 1'b0);
    vecs[3]  = mk(1'b0, 32'h0C, 32'h0, 32'h0, 1'b0);
    vecs[4]  = mk(1'b0, 32'h14, 32'h0, 32'h0, 1'b0);
    vecs[5]  = mk(1'b1, 32'h00, 32'h0000_3135, 32'h0, 1'b0);
    vecs[6]  = mk(1'b1, 32'h04, 32'h3238_2E44, 32'h0, 1'b0);
    vecs[7]  = mk(1'b1, 32'h08, 32'h4C49_5456, 32'h0, 1'b0);
    vecs[8]  = mk(1'b1, 32'h0C, 32'h4441_5259, 32'h0, 1'b0);
    vecs[9]  = mk(1'b0, 32'h00, 32'h0, 32'h0000_3135, 1'b0);
    vecs[10] = mk(1'b0, 32'h04, 32'h0, 32'h3238_2E44, 1'b0);
    vecs[11] = mk(1'b0, 32'h08, 32'h0, 32'h4C49_5456, 1'b0);
    vecs[12] = mk(1'b0, 32'h0C, 32'h0, 32'h4441_5259, 1'b0);
    vecs[13] = mk(1'b0, 32'h14, 32'h0, 32'h0000_0004, 1'b0);
    vecs[14] = mk(1'b0, 32'h10, 32'h0, ID, 1'b0);
    vecs[15] = mk(1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b1);
    vecs[16] = mk(1'b0, 32'h10, 32'h0, ID, 1'b0);
    vecs[17] = mk(1'b0, 32'h18, 32'h0, 32'h0, 1'b1);
    vecs[18] = mk(1'b1, 32'h02, 32'hFFFF_FFFF, 32'h0, 1'b1);
    vecs[19] = mk(1'b0, 32'h00, 32'h0, 32'h0000_3135, 1'b0);
    vecs[20] = mk(1'b0, 32'h14, 32'h0, 32'h0000_0004, 1'b0);

    // Reset state on all three instances.
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset_pready_dut%0d", d), {31'd0, pready_a[d]}, 32'd0);
      check($sformatf("reset_pslverr_dut%0d", d), {31'd0, pslverr_a[d]}, 32'd0);
      check($sformatf("reset_prdata_dut%0d", d), prdata_a[d], 32'd0);
    end
    rst = 1'b0;

    // Directed table on the one-wait-state instance.
    for (int i = 0; i < 21; i++) begin
      do_xfer(1, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, e, erd, ee);
      check($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
      if (!vecs[i].wr || vecs[i].exp_err) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
    end
    idle(1);

    // Zero and three wait states, back-to-back transfers.
    check_xfer(0, 1'b1, 32'h04, 32'hCAFE_0004, "ws0_w04");
    check_xfer(0, 1'b0, 32'h04, 32'h0, "ws0_r04");
    check_xfer(0, 1'b0, 32'h14, 32'h0, "ws0_rcnt");
    idle(0);
    check_xfer(2, 1'b1, 32'h0C, 32'h1357_9BDF, "ws3_w0c");
    check_xfer(2, 1'b0, 32'h0C, 32'h0, "ws3_r0c");
    check_xfer(2, 1'b0, 32'h10, 32'h0, "ws3_rid");
    idle(2);

    // PSEL dropped in the single wait cycle of a write to 0x08.
    @(negedge clk);
    psel_a[1] = 1'b1; penable_a[1] = 1'b0; pwrite_a[1] = 1'b1;
    paddr_a[1] = 32'h08; pwdata_a[1] = 32'h1111_1111;
    @(negedge clk);
    psel_a[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("abort_ws1_pready", {31'd0, pready_a[1]}, 32'd0);
      @(negedge clk);
    end
    check_xfer(1, 1'b0, 32'h08, 32'h0, "abort_ws1_r08");
    check_xfer(1, 1'b0, 32'h14, 32'h0, "abort_ws1_rcnt");
    idle(1);

    // PSEL dropped in the second of three wait cycles.
    @(negedge clk);
    psel_a[2] = 1'b1; penable_a[2] = 1'b0; pwrite_a[2] = 1'b1;
    paddr_a[2] = 32'h08; pwdata_a[2] = 32'h2222_2222;
    @(negedge clk);
    penable_a[2] = 1'b1;
    @(negedge clk);
    check("abort_ws3_pready_mid", {31'd0, pready_a[2]}, 32'd0);
    psel_a[2] = 1'b0; penable_a[2] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("abort_ws3_pready", {31'd0, pready_a[2]}, 32'd0);
    end
    check_xfer(2, 1'b0, 32'h08, 32'h0, "abort_ws3_r08");
    check_xfer(2, 1'b0, 32'h14, 32'h0, "abort_ws3_rcnt");
    idle(2);

    // Randomised traffic against the model.
    pool[0] = 32'h00; pool[1] = 32'h04; pool[2] = 32'h08; pool[3] = 32'h0C; pool[4] = 32'h10;
    pool[5] = 32'h14; pool[6] = 32'h18; pool[7] = 32'h02; pool[8] = 32'h100;
    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 50; n++) begin
        int          sel;
        logic [31:0] a;
        sel = int'($urandom_range(0, 9));
        a = (sel == 9) ? ($urandom & 32'h1F) : pool[sel];
        check_xfer(d, 1'($urandom % 2), a, $urandom, $sformatf("rand_dut%0d_%0d", d, n));
        if ($urandom % 4 == 0) idle(d);
      end
      idle(d);
    end

    // Reset while a write is in its completion cycle.
    @(negedge clk);
    psel_a[1] = 1'b1; penable_a[1] = 1'b0; pwrite_a[1] = 1'b1;
    paddr_a[1] = 32'h00; pwdata_a[1] = 32'h5555_5555;
    @(negedge clk);
    penable_a[1] = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    psel_a[1] = 1'b0; penable_a[1] = 1'b0;
    check("midreset_pready", {31'd0, pready_a[1]}, 32'd0);
    model_reset();
    for (int a = 0; a < 6; a++) begin
      do_xfer(1, 1'b0, 32'(a * 4), 32'h0, rd, e, erd, ee);
      check($sformatf("midreset_r%02h", a * 4), rd, (a == 4) ? ID : 32'd0);
    end
    idle(1);

    // Write counter wraps at 256.
    for (int i = 0; i < 256; i++) do_xfer(0, 1'b1, 32'h00, 32'(i), rd, e, erd, ee);
    do_xfer(0, 1'b0, 32'h14, 32'h0, rd, e, erd, ee);
    check("wrap_cnt_256", rd, 32'd0);
    do_xfer(0, 1'b1, 32'h00, 32'h1234_5678, rd, e, erd, ee);
    do_xfer(0, 1'b0, 32'h14, 32'h0, rd, e, erd, ee);
    check("wrap_cnt_257", rd, 32'd1);
    do_xfer(0, 1'b0, 32'h00, 32'h0, rd, e, erd, ee);
    check("wrap_r00", rd, 32'h1234_5678);
    idle(0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
